// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: per-core local barrier controller.
//
// Warps arrive at one of NUM_BARRIERS named barriers. Each arriving warp is held
// in stalled_mask until the barrier's declared warp count is reached. The whole
// group is then released with a one-cycle pulse.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   arrive_valid/ready           arrival handshake; ready is low only while the
//                                addressed barrier is in its RELEASE cycle
//   arrive_wid/bar_id/size_m1    arriving warp, target barrier, group size - 1
//   kill_valid/kill_wid          remove a warp from every barrier
//   stalled_mask                 warps currently held at any barrier (registered)
//   release_valid/mask/bars      one-cycle registered release pulse
//   err_dup                      sticky: warp arrived twice at the same barrier
//   err_timeout                  sticky: a barrier timed out
//   busy                         any barrier not IDLE
//
// Optional feature macro: BARRIER_TIMEOUT_EN. When it is defined, a barrier that
// stays in COLLECT for TIMEOUT_CYCLES cycles force-releases its current mask and
// sets err_timeout. When it is undefined, barriers wait indefinitely and
// err_timeout is tied low.
module vx_barrier_ctrl #(
  parameter int NUM_WARPS      = 4,
  parameter int NUM_BARRIERS   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int NW_WIDTH      = $clog2(NUM_WARPS),
  localparam int NB_WIDTH      = $clog2(NUM_BARRIERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arrive_valid,
  output logic                    arrive_ready,
  input  logic [NW_WIDTH-1:0]     arrive_wid,
  input  logic [NB_WIDTH-1:0]     arrive_bar_id,
  input  logic [NW_WIDTH-1:0]     arrive_size_m1,
  input  logic                    kill_valid,
  input  logic [NW_WIDTH-1:0]     kill_wid,
  output logic [NUM_WARPS-1:0]    stalled_mask,
  output logic                    release_valid,
  output logic [NUM_WARPS-1:0]    release_mask,
  output logic [NUM_BARRIERS-1:0] release_bars,
  output logic                    err_dup,
  output logic                    err_timeout,
  output logic                    busy
);

  localparam int CNT_WIDTH = $clog2(NUM_WARPS + 1);
  localparam logic [NUM_WARPS-1:0] ZERO_W = {NUM_WARPS{1'b0}};
  localparam logic [NUM_WARPS-1:0] ONE_W  = {{(NUM_WARPS-1){1'b0}}, 1'b1};

  // A nonsensical timeout length is rejected at elaboration.
  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("vx_barrier_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_WARPS-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < NUM_WARPS; i++) begin
      c = c + {{(CNT_WIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_e                   state_q [NUM_BARRIERS];
  state_e                   state_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]     mask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]     mask_d  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]      size_q  [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]      size_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]     stalled_mask_q, stalled_mask_d;
  logic                     release_valid_q, release_valid_d;
  logic [NUM_WARPS-1:0]     release_mask_q, release_mask_d;
  logic [NUM_BARRIERS-1:0]  release_bars_q, release_bars_d;
  logic                     err_dup_q, err_dup_d;
`ifdef BARRIER_TIMEOUT_EN
  localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TMR_WIDTH-1:0]     timer_q [NUM_BARRIERS];
  logic [TMR_WIDTH-1:0]     timer_d [NUM_BARRIERS];
  logic                     err_timeout_q, err_timeout_d;
`endif

  logic                     arrive_fire;
  logic                     kill_arrival;
  logic                     hit;
  logic [NUM_WARPS-1:0]     arrive_bit;
  logic [NUM_WARPS-1:0]     kill_bit;
  logic [NUM_WARPS-1:0]     mask_n;
  logic [NW_WIDTH-1:0]      eff_size;

  // Arrival handshake: blocked only while the target barrier emits its release.
  always_comb begin
    arrive_ready = (state_q[arrive_bar_id] != ST_RELEASE);
  end

  // Busy whenever any barrier has left IDLE.
  always_comb begin
    busy = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      busy = busy | (state_q[b] != ST_IDLE);
    end
  end

  // Per-barrier next state, masks, release pulse and error flags.
  always_comb begin
    arrive_fire     = arrive_valid && arrive_ready;
    arrive_bit      = ONE_W << arrive_wid;
    kill_bit        = kill_valid ? (ONE_W << kill_wid) : ZERO_W;
    kill_arrival    = kill_valid && (kill_wid == arrive_wid);
    release_valid_d = 1'b0;
    release_mask_d  = ZERO_W;
    release_bars_d  = {NUM_BARRIERS{1'b0}};
    err_dup_d       = err_dup_q;
    stalled_mask_d  = ZERO_W;
    hit             = 1'b0;
    mask_n          = ZERO_W;
    eff_size        = {NW_WIDTH{1'b0}};
`ifdef BARRIER_TIMEOUT_EN
    err_timeout_d   = err_timeout_q;
`endif
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      hit        = arrive_fire && (arrive_bar_id == NB_WIDTH'(b));
      mask_n     = mask_q[b] | arrive_bit;
      // The first arrival defines the group size; later sizes are ignored.
      eff_size   = (state_q[b] == ST_IDLE) ? arrive_size_m1 : size_q[b];
      state_d[b] = state_q[b];
      mask_d[b]  = mask_q[b] & ~kill_bit;
      size_d[b]  = size_q[b];
`ifdef BARRIER_TIMEOUT_EN
      timer_d[b] = (state_q[b] == ST_COLLECT) ? (timer_q[b] + {{(TMR_WIDTH-1){1'b0}}, 1'b1})
                                              : {TMR_WIDTH{1'b0}};
      if (hit) begin
        timer_d[b] = {TMR_WIDTH{1'b0}};
      end else begin
        timer_d[b] = timer_d[b];
      end
`endif
      case (state_q[b])
        ST_IDLE, ST_COLLECT: begin
          if (hit && kill_arrival) begin
            // Kill beats a same-cycle arrival of the same warp: arrival is dropped.
            state_d[b] = state_q[b];
          end else if (hit && ((mask_q[b] & arrive_bit) != ZERO_W)) begin
            err_dup_d = 1'b1;
          end else if (hit) begin
            size_d[b] = eff_size;
            if (popcount(mask_n) == (CNT_WIDTH'(eff_size) + CNT_WIDTH'(1'b1))) begin
              state_d[b]        = ST_RELEASE;
              mask_d[b]         = ZERO_W;
              release_valid_d   = 1'b1;
              release_mask_d    = release_mask_d | (mask_n & ~kill_bit);
              release_bars_d[b] = 1'b1;
            end else begin
              state_d[b] = ST_COLLECT;
              mask_d[b]  = mask_n & ~kill_bit;
            end
          end else begin
`ifdef BARRIER_TIMEOUT_EN
            if ((state_q[b] == ST_COLLECT) && (timer_q[b] == TMR_LAST) && (mask_d[b] != ZERO_W)) begin
              state_d[b]        = ST_RELEASE;
              release_valid_d   = 1'b1;
              release_mask_d    = release_mask_d | mask_d[b];
              release_bars_d[b] = 1'b1;
              err_timeout_d     = 1'b1;
              mask_d[b]         = ZERO_W;
            end else begin
              state_d[b] = state_q[b];
            end
`else
            state_d[b] = state_q[b];
`endif
          end
          // A collecting barrier whose warps were all killed goes back to IDLE.
          state_d[b] = ((state_d[b] == ST_COLLECT) && (mask_d[b] == ZERO_W)) ? ST_IDLE : state_d[b];
        end
        ST_RELEASE: begin
          state_d[b] = ST_IDLE;
          mask_d[b]  = ZERO_W;
        end
        default: begin
          state_d[b] = ST_IDLE;
          mask_d[b]  = ZERO_W;
        end
      endcase
      stalled_mask_d = stalled_mask_d | ((state_d[b] == ST_COLLECT) ? mask_d[b] : ZERO_W);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= ST_IDLE;
        mask_q[b]  <= ZERO_W;
        size_q[b]  <= {NW_WIDTH{1'b0}};
`ifdef BARRIER_TIMEOUT_EN
        timer_q[b] <= {TMR_WIDTH{1'b0}};
`endif
      end
      stalled_mask_q  <= ZERO_W;
      release_valid_q <= 1'b0;
      release_mask_q  <= ZERO_W;
      release_bars_q  <= {NUM_BARRIERS{1'b0}};
      err_dup_q       <= 1'b0;
`ifdef BARRIER_TIMEOUT_EN
      err_timeout_q   <= 1'b0;
`endif
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        state_q[b] <= state_d[b];
        mask_q[b]  <= mask_d[b];
        size_q[b]  <= size_d[b];
`ifdef BARRIER_TIMEOUT_EN
        timer_q[b] <= timer_d[b];
`endif
      end
      stalled_mask_q  <= stalled_mask_d;
      release_valid_q <= release_valid_d;
      release_mask_q  <= release_mask_d;
      release_bars_q  <= release_bars_d;
      err_dup_q       <= err_dup_d;
`ifdef BARRIER_TIMEOUT_EN
      err_timeout_q   <= err_timeout_d;
`endif
    end
  end

  assign stalled_mask  = stalled_mask_q;
  assign release_valid = release_valid_q;
  assign release_mask  = release_mask_q;
  assign release_bars  = release_bars_q;
  assign err_dup       = err_dup_q;
`ifdef BARRIER_TIMEOUT_EN
  assign err_timeout   = err_timeout_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Directed testbench for vx_barrier_ctrl (4 warps, 4 barriers, timeout 16).
module tb_vx_barrier_ctrl;

  logic       clk;
  logic       reset;
  logic       arrive_valid;
  logic       arrive_ready;
  logic [1:0] arrive_wid;
  logic [1:0] arrive_bar_id;
  logic [1:0] arrive_size_m1;
  logic       kill_valid;
  logic [1:0] kill_wid;
  logic [3:0] stalled_mask;
  logic       release_valid;
  logic [3:0] release_mask;
  logic [3:0] release_bars;
  logic       err_dup;
  logic       err_timeout;
  logic       busy;

  int n_checks;
  int n_errors;
  int rel_at;
  logic [3:0] rel_mask;

  vx_barrier_ctrl #(
    .NUM_WARPS(4),
    .NUM_BARRIERS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .arrive_valid(arrive_valid),
    .arrive_ready(arrive_ready),
    .arrive_wid(arrive_wid),
    .arrive_bar_id(arrive_bar_id),
    .arrive_size_m1(arrive_size_m1),
    .kill_valid(kill_valid),
    .kill_wid(kill_wid),
    .stalled_mask(stalled_mask),
    .release_valid(release_valid),
    .release_mask(release_mask),
    .release_bars(release_bars),
    .err_dup(err_dup),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    arrive_valid   = 1'b0;
    arrive_wid     = 2'd0;
    arrive_bar_id  = 2'd0;
    arrive_size_m1 = 2'd0;
    kill_valid     = 1'b0;
    kill_wid       = 2'd0;
  endtask

  task automatic arrive(input logic [1:0] wid, input logic [1:0] bar, input logic [1:0] szm1);
    arrive_valid   = 1'b1;
    arrive_wid     = wid;
    arrive_bar_id  = bar;
    arrive_size_m1 = szm1;
  endtask

  task automatic kill(input logic [1:0] wid);
    kill_valid = 1'b1;
    kill_wid   = wid;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_ready", 32'(arrive_ready), 32'd1);
    check_eq("rst_stalled", 32'(stalled_mask), 32'h0);
    check_eq("rst_rel_valid", 32'(release_valid), 32'd0);
    check_eq("rst_rel_mask", 32'(release_mask), 32'h0);
    check_eq("rst_rel_bars", 32'(release_bars), 32'h0);
    check_eq("rst_err_dup", 32'(err_dup), 32'd0);
    check_eq("rst_err_to", 32'(err_timeout), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // 1. Two-warp barrier: wid0 then wid3 at bar2; later size field ignored.
    arrive(2'd0, 2'd2, 2'd1);
    tick();
    idle_in();
    check_eq("t1_stall_c2", 32'(stalled_mask), 32'h1);
    check_eq("t1_busy_c2", 32'(busy), 32'd1);
    check_eq("t1_norel_c2", 32'(release_valid), 32'd0);
    tick();
    check_eq("t1_stall_c3", 32'(stalled_mask), 32'h1);
    tick();
    check_eq("t1_stall_c4", 32'(stalled_mask), 32'h1);
    arrive(2'd3, 2'd2, 2'd3);
    tick();
    idle_in();
    check_eq("t1_rel_valid", 32'(release_valid), 32'd1);
    check_eq("t1_rel_mask", 32'(release_mask), 32'h9);
    check_eq("t1_rel_bars", 32'(release_bars), 32'h4);
    check_eq("t1_stall_c5", 32'(stalled_mask), 32'h0);
    tick();
    check_eq("t1_rel_done", 32'(release_valid), 32'd0);
    check_eq("t1_idle", 32'(busy), 32'd0);

    // 2. Single-warp barrier releases at once.
    arrive(2'd2, 2'd0, 2'd0);
    tick();
    idle_in();
    check_eq("t2_rel_valid", 32'(release_valid), 32'd1);
    check_eq("t2_rel_mask", 32'(release_mask), 32'h4);
    check_eq("t2_rel_bars", 32'(release_bars), 32'h1);
    check_eq("t2_stall", 32'(stalled_mask), 32'h0);
    tick();

    // 3. Arrival during RELEASE cycle is held off for one cycle.
    arrive(2'd0, 2'd1, 2'd0);
    tick();
    check_eq("t3_rel_mask", 32'(release_mask), 32'h1);
    check_eq("t3_rel_bars", 32'(release_bars), 32'h2);
    arrive(2'd1, 2'd1, 2'd1);
    #1;
    check_eq("t3_ready_low", 32'(arrive_ready), 32'd0);
    tick();
    check_eq("t3_ready_high", 32'(arrive_ready), 32'd1);
    check_eq("t3_no_rel", 32'(release_valid), 32'd0);
    tick();
    idle_in();
    check_eq("t3_stall", 32'(stalled_mask), 32'h2);
    check_eq("t3_busy", 32'(busy), 32'd1);
    arrive(2'd2, 2'd1, 2'd0);
    tick();
    idle_in();
    check_eq("t3_rel2_mask", 32'(release_mask), 32'h6);
    check_eq("t3_rel2_bars", 32'(release_bars), 32'h2);
    tick();

    // 4. Duplicate arrival flags err_dup and leaves the mask alone.
    arrive(2'd1, 2'd3, 2'd2);
    tick();
    idle_in();
    check_eq("t4_dup_clear", 32'(err_dup), 32'd0);
    arrive(2'd1, 2'd3, 2'd2);
    tick();
    idle_in();
    check_eq("t4_err_dup", 32'(err_dup), 32'd1);
    check_eq("t4_stall", 32'(stalled_mask), 32'h2);
    check_eq("t4_no_rel", 32'(release_valid), 32'd0);
    kill(2'd1);
    tick();
    idle_in();
    check_eq("t4_kill_stall", 32'(stalled_mask), 32'h0);
    check_eq("t4_kill_busy", 32'(busy), 32'd0);
    check_eq("t4_dup_sticky", 32'(err_dup), 32'd1);

    // 5. Kills drain a collecting barrier without a release.
    arrive(2'd0, 2'd0, 2'd3);
    tick();
    arrive(2'd1, 2'd0, 2'd3);
    tick();
    idle_in();
    check_eq("t5_stall2", 32'(stalled_mask), 32'h3);
    kill(2'd1);
    tick();
    idle_in();
    check_eq("t5_kill1_stall", 32'(stalled_mask), 32'h1);
    check_eq("t5_kill1_busy", 32'(busy), 32'd1);
    kill(2'd0);
    tick();
    idle_in();
    check_eq("t5_kill0_stall", 32'(stalled_mask), 32'h0);
    check_eq("t5_kill0_busy", 32'(busy), 32'd0);
    check_eq("t5_no_rel", 32'(release_valid), 32'd0);

    // Same-cycle kill and arrival of one warp: the arrival has no effect.
    arrive(2'd3, 2'd2, 2'd0);
    kill(2'd3);
    tick();
    idle_in();
    check_eq("kill_arr_rel", 32'(release_valid), 32'd0);
    check_eq("kill_arr_busy", 32'(busy), 32'd0);

    // Reset mid-operation discards pending warps.
    arrive(2'd0, 2'd0, 2'd1);
    tick();
    check_eq("mid_rst_stall_pre", 32'(stalled_mask), 32'h1);
    arrive(2'd1, 2'd0, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    check_eq("mid_rst_stall", 32'(stalled_mask), 32'h0);
    check_eq("mid_rst_rel", 32'(release_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_dup", 32'(err_dup), 32'd0);
    tick();
    check_eq("mid_rst_rel2", 32'(release_valid), 32'd0);

    // 6. Lone warp at a 4-warp barrier: timeout release, or waits forever.
    arrive(2'd2, 2'd1, 2'd3);
    rel_at   = 0;
    rel_mask = 4'h0;
`ifdef BARRIER_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
`else
    for (int k = 1; k <= 10000; k++) begin
`endif
      tick();
      idle_in();
      if (release_valid && (rel_at == 0)) begin
        rel_at   = k;
        rel_mask = release_mask;
      end
    end
`ifdef BARRIER_TIMEOUT_EN
    check_eq("t6_rel_cycle", 32'(rel_at), 32'd17);
    check_eq("t6_rel_mask", 32'(rel_mask), 32'h4);
    check_eq("t6_err_to", 32'(err_timeout), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd0);
`else
    check_eq("t6_no_rel", 32'(rel_at), 32'd0);
    check_eq("t6_err_to", 32'(err_timeout), 32'd0);
    check_eq("t6_stall", 32'(stalled_mask), 32'h4);
    check_eq("t6_busy", 32'(busy), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
